write_back: RTL and testbench

//  Final pipeline stage, directly downstream of the memory-access stage. Selects the ALU result,

---
 rtl/write_back_pkg.sv | 13 +
 rtl/write_back_if.sv | 40 ++++
 rtl/write_back.sv | 121 ++++++++++++
 tb/tb_write_back.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_back_pkg.sv
// rtl/write_back_pkg.sv - shared types and constants for the write-back stage
package write_back_pkg;

    typedef enum logic {
        WB_RUN,
        WB_WAIT_LOAD
    } t_wb_state;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

endpackage

// File: rtl/write_back_if.sv
// rtl/write_back_if.sv - pipeline, cache and register-file signals of the write-back stage
interface write_back_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
);
    logic                  i_en;
    logic                  i_valid;
    logic [DATA_W-1:0]     i_pcplus4;
    logic [REG_ADDR_W-1:0] i_rdest;
    logic                  i_cu_regwrite;
    logic [1:0]            i_cu_memtoreg;
    logic [DATA_W-1:0]     i_exe_data;
    logic [DATA_W-1:0]     i_mem_data;
    logic                  i_mem_valid;
    logic                  o_rf_we;
    logic [REG_ADDR_W-1:0] o_rf_waddr;
    logic [DATA_W-1:0]     o_rf_wdata;
    logic                  o_fwd_valid;
    logic [REG_ADDR_W-1:0] o_fwd_rdest;
    logic [DATA_W-1:0]     o_fwd_data;
    logic                  o_stall;
    logic [CNT_W-1:0]      o_instret;
    logic                  o_load_timeout;

    modport master (
        output i_en, i_valid, i_pcplus4, i_rdest, i_cu_regwrite, i_cu_memtoreg,
               i_exe_data, i_mem_data, i_mem_valid,
        input  o_rf_we, o_rf_waddr, o_rf_wdata, o_fwd_valid, o_fwd_rdest, o_fwd_data,
               o_stall, o_instret, o_load_timeout
    );

    modport slave (
        input  i_en, i_valid, i_pcplus4, i_rdest, i_cu_regwrite, i_cu_memtoreg,
               i_exe_data, i_mem_data, i_mem_valid,
        output o_rf_we, o_rf_waddr, o_rf_wdata, o_fwd_valid, o_fwd_rdest, o_fwd_data,
               o_stall, o_instret, o_load_timeout
    );

endinterface

// File: rtl/write_back.sv
// rtl/write_back.sv - final pipeline stage: result select, register-file write, load wait
module write_back
    import write_back_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         i_aclk,
    input  logic         i_areset_n,
    write_back_if.slave  wb
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    t_wb_state             r_state;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;
    logic [REG_ADDR_W-1:0] r_pend_rd;
    logic [CNT_W-1:0]      r_instret;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_load_timeout;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_load_wait;
    logic                  w_load_done;
    logic                  w_retire;
    logic [DATA_W-1:0]     w_sel_data;

    // A load whose data is not back yet parks the stage; a returning load or
    // any other accepted slot retires.
    assign w_accept    = wb.i_en & wb.i_valid & (r_state == WB_RUN);
    assign w_load      = w_accept & wb.i_cu_regwrite & (wb.i_cu_memtoreg == MTR_MEM);
    assign w_load_wait = w_load & ~wb.i_mem_valid;
    assign w_load_done = (r_state == WB_WAIT_LOAD) & wb.i_mem_valid;
    assign w_retire    = (w_accept & ~w_load_wait) | w_load_done;

    // Result mux; the unused memtoreg code falls back to the ALU result.
    always_comb begin
        w_sel_data = wb.i_exe_data;
        case (wb.i_cu_memtoreg)
            MTR_MEM: w_sel_data = wb.i_mem_data;
            MTR_PC:  w_sel_data = wb.i_pcplus4;
            default: w_sel_data = wb.i_exe_data;
        endcase
    end

    // Stage FSM driving the registered register-file write port.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_state    <= WB_RUN;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_pend_rd  <= '0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                WB_RUN: begin
                    if (w_load_wait) begin
                        r_pend_rd <= wb.i_rdest;
                        r_state   <= WB_WAIT_LOAD;
                    end else if (w_accept) begin
                        r_rf_we    <= wb.i_cu_regwrite & (wb.i_rdest != '0);
                        r_rf_waddr <= wb.i_rdest;
                        r_rf_wdata <= w_sel_data;
                    end
                end
                WB_WAIT_LOAD: begin
                    if (wb.i_mem_valid) begin
                        r_rf_we    <= (r_pend_rd != '0);
                        r_rf_waddr <= r_pend_rd;
                        r_rf_wdata <= wb.i_mem_data;
                        r_state    <= WB_RUN;
                    end
                end
                default: r_state <= WB_RUN;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Load-wait watchdog; the flag is sticky but the stage keeps waiting.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_timer        <= '0;
            r_load_timeout <= 1'b0;
        end else if (w_load_wait) begin
            r_timer <= '0;
        end else if ((r_state == WB_WAIT_LOAD) && !wb.i_mem_valid) begin
            if (r_timer == TMR_LAST) begin
                r_load_timeout <= 1'b1;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign wb.o_stall        = (r_state == WB_WAIT_LOAD) ? ~wb.i_mem_valid : w_load_wait;
    assign wb.o_rf_we        = r_rf_we;
    assign wb.o_rf_waddr     = r_rf_waddr;
    assign wb.o_rf_wdata     = r_rf_wdata;
    assign wb.o_fwd_valid    = r_rf_we;
    assign wb.o_fwd_rdest    = r_rf_waddr;
    assign wb.o_fwd_data     = r_rf_wdata;
    assign wb.o_instret      = r_instret;
    assign wb.o_load_timeout = r_load_timeout;

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - scoreboard testbench for write_back
module tb_write_back;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } t_wr;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;
    longint unsigned exp_inst;
    t_wr  sb[$];

    write_back_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(64)) wb_if ();

    write_back #(
        .DATA_W(32), .REG_ADDR_W(5), .CNT_W(64), .TIMEOUT_CYC(8)
    ) dut (
        .i_aclk     (clk),
        .i_areset_n (rstn),
        .wb         (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] mtr, input logic [31:0] exe, input logic [31:0] mem,
                         input logic memv, input logic [31:0] pc4);
        wb_if.i_en          = en;
        wb_if.i_valid       = v;
        wb_if.i_cu_regwrite = rw;
        wb_if.i_rdest       = rd;
        wb_if.i_cu_memtoreg = mtr;
        wb_if.i_exe_data    = exe;
        wb_if.i_mem_data    = mem;
        wb_if.i_mem_valid   = memv;
        wb_if.i_pcplus4     = pc4;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Scoreboard: every write-port pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rstn && wb_if.o_rf_we) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: write addr=%0d data=%h, required none",
                         wb_if.o_rf_waddr, wb_if.o_rf_wdata);
            end else begin
                t_wr e;
                e = sb.pop_front();
                if (wb_if.o_rf_waddr !== e.addr || wb_if.o_rf_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL sb_write: got %0d/%h, required %0d/%h",
                             wb_if.o_rf_waddr, wb_if.o_rf_wdata, e.addr, e.data);
                end
                n_cmp++;
                if (wb_if.o_fwd_valid !== 1'b1 || wb_if.o_fwd_rdest !== e.addr ||
                    wb_if.o_fwd_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_fwd: got %b/%0d/%h, required 1/%0d/%h", wb_if.o_fwd_valid,
                             wb_if.o_fwd_rdest, wb_if.o_fwd_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        tick();
        tick();
        rstn = 1'b1;
        exp_inst = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b0 || wb_if.o_rf_waddr !== 5'd0 || wb_if.o_rf_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_port: got %b/%0d/%h, required 0/0/0",
                     wb_if.o_rf_we, wb_if.o_rf_waddr, wb_if.o_rf_wdata);
        end
        n_cmp++;
        if (wb_if.o_instret !== 64'd0 || wb_if.o_load_timeout !== 1'b0 || wb_if.o_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_misc: instret=%0d timeout=%b stall=%b, required 0/0/0",
                     wb_if.o_instret, wb_if.o_load_timeout, wb_if.o_stall);
        end
    endtask

    task automatic test_alu();
        drive(1, 1, 1, 5'd5, 2'b00, 32'h1234, 32'hDEAD, 0, 32'h4);
        sb.push_back('{5'd5, 32'h1234});
        exp_inst++;
        tick();
        drive(1, 1, 1, 5'd6, 2'b11, 32'hBEEF, 32'h9999, 0, 32'h8);
        sb.push_back('{5'd6, 32'hBEEF});
        exp_inst++;
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b1 || wb_if.o_instret !== 64'd1) begin
            n_err++;
            $display("FAIL alu_first: we=%b instret=%0d, required 1/1", wb_if.o_rf_we, wb_if.o_instret);
        end
        tick();
        idle();
        tick();
        n_cmp++;
        if (sb.size() != 0 || wb_if.o_instret !== exp_inst) begin
            n_err++;
            $display("FAIL alu_done: pending=%0d instret=%0d, required 0/%0d",
                     sb.size(), wb_if.o_instret, exp_inst);
        end
    endtask

    task automatic test_jal();
        drive(1, 1, 1, 5'd1, 2'b10, 32'hDEAD, 32'h5555, 0, 32'h80);
        sb.push_back('{5'd1, 32'h80});
        exp_inst++;
        tick();
        drive(1, 1, 1, 5'd0, 2'b10, 32'hDEAD, 32'h5555, 0, 32'h84);
        exp_inst++;
        n_cmp++;
        if (wb_if.o_rf_wdata !== 32'h80) begin
            n_err++;
            $display("FAIL jal_link: got %h, required 00000080", wb_if.o_rf_wdata);
        end
        tick();
        idle();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b0 || wb_if.o_instret !== exp_inst) begin
            n_err++;
            $display("FAIL jal_x0: we=%b instret=%0d, required 0/%0d",
                     wb_if.o_rf_we, wb_if.o_instret, exp_inst);
        end
        tick();
    endtask

    task automatic test_load_miss();
        drive(1, 1, 1, 5'd7, 2'b01, 32'h55, 32'h0, 0, 32'h0);
        #1;
        n_cmp++;
        if (wb_if.o_stall !== 1'b1) begin
            n_err++;
            $display("FAIL miss_stall_now: got %b, required 1", wb_if.o_stall);
        end
        exp_inst++;
        tick();
        drive(1, 1, 1, 5'd9, 2'b00, 32'h666, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (wb_if.o_stall !== 1'b1 || wb_if.o_rf_we !== 1'b0) begin
                n_err++;
                $display("FAIL miss_wait%0d: stall=%b we=%b, required 1/0", i, wb_if.o_stall, wb_if.o_rf_we);
            end
            tick();
        end
        wb_if.i_mem_valid = 1'b1;
        wb_if.i_mem_data  = 32'hFFFFFF80;
        #1;
        n_cmp++;
        if (wb_if.o_stall !== 1'b0) begin
            n_err++;
            $display("FAIL miss_stall_drop: got %b, required 0", wb_if.o_stall);
        end
        sb.push_back('{5'd7, 32'hFFFFFF80});
        tick();
        idle();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b1 || wb_if.o_instret !== exp_inst) begin
            n_err++;
            $display("FAIL miss_write: we=%b instret=%0d, required 1/%0d",
                     wb_if.o_rf_we, wb_if.o_instret, exp_inst);
        end
        tick();
        n_cmp++;
        if (wb_if.o_instret !== exp_inst || sb.size() != 0) begin
            n_err++;
            $display("FAIL miss_once: instret=%0d pending=%0d, required %0d/0",
                     wb_if.o_instret, sb.size(), exp_inst);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 1, 5'd3, 2'b01, 32'h0, 32'hA5A5A5A5, 1, 32'h0);
        #1;
        n_cmp++;
        if (wb_if.o_stall !== 1'b0) begin
            n_err++;
            $display("FAIL hit_stall: got %b, required 0", wb_if.o_stall);
        end
        sb.push_back('{5'd3, 32'hA5A5A5A5});
        exp_inst++;
        tick();
        drive(1, 1, 1, 5'd4, 2'b00, 32'h77, 32'h0, 0, 32'h0);
        sb.push_back('{5'd4, 32'h77});
        exp_inst++;
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: we=%b, required 1", wb_if.o_rf_we);
        end
        tick();
        idle();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: we=%b, required 1", wb_if.o_rf_we);
        end
        tick();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b0 || sb.size() != 0 || wb_if.o_instret !== exp_inst) begin
            n_err++;
            $display("FAIL b2b_end: we=%b pending=%0d instret=%0d, required 0/0/%0d",
                     wb_if.o_rf_we, sb.size(), wb_if.o_instret, exp_inst);
        end
    endtask

    task automatic test_timeout();
        drive(1, 1, 1, 5'd12, 2'b01, 32'h0, 32'h0, 0, 32'h0);
        exp_inst++;
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (wb_if.o_load_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: got %b, required 0", wb_if.o_load_timeout);
        end
        tick();
        tick();
        n_cmp++;
        if (wb_if.o_load_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_set: got %b, required 1", wb_if.o_load_timeout);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (wb_if.o_load_timeout !== 1'b1 || wb_if.o_stall !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: flag=%b stall=%b, required 1/1",
                     wb_if.o_load_timeout, wb_if.o_stall);
        end
        wb_if.i_mem_valid = 1'b1;
        wb_if.i_mem_data  = 32'h11112222;
        sb.push_back('{5'd12, 32'h11112222});
        tick();
        idle();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b1 || wb_if.o_instret !== exp_inst || wb_if.o_load_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_complete: we=%b instret=%0d flag=%b, required 1/%0d/1",
                     wb_if.o_rf_we, wb_if.o_instret, wb_if.o_load_timeout, exp_inst);
        end
        tick();
        do_reset();
        n_cmp++;
        if (wb_if.o_load_timeout !== 1'b0 || wb_if.o_instret !== 64'd0) begin
            n_err++;
            $display("FAIL timeout_reset: flag=%b instret=%0d, required 0/0",
                     wb_if.o_load_timeout, wb_if.o_instret);
        end
    endtask

    task automatic test_reset_wait_and_bubbles();
        drive(1, 1, 1, 5'd15, 2'b01, 32'h0, 32'h0, 0, 32'h0);
        tick();
        idle();
        n_cmp++;
        if (wb_if.o_stall !== 1'b1) begin
            n_err++;
            $display("FAIL rw_waiting: stall=%b, required 1", wb_if.o_stall);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_inst = 0;
        n_cmp++;
        if (wb_if.o_stall !== 1'b0 || wb_if.o_rf_we !== 1'b0 || wb_if.o_instret !== 64'd0) begin
            n_err++;
            $display("FAIL rw_abandon: stall=%b we=%b instret=%0d, required 0/0/0",
                     wb_if.o_stall, wb_if.o_rf_we, wb_if.o_instret);
        end
        drive(1, 0, 1, 5'd6, 2'b01, 32'h0, 32'hCAFE, 1, 32'h0);
        tick();
        drive(0, 1, 1, 5'd6, 2'b00, 32'h42, 32'h0, 0, 32'h0);
        tick();
        drive(1, 1, 0, 5'd8, 2'b00, 32'h43, 32'h0, 0, 32'h0);
        exp_inst++;
        tick();
        idle();
        n_cmp++;
        if (wb_if.o_rf_we !== 1'b0 || wb_if.o_instret !== exp_inst) begin
            n_err++;
            $display("FAIL bubble_count: we=%b instret=%0d, required 0/%0d",
                     wb_if.o_rf_we, wb_if.o_instret, exp_inst);
        end
        drive(1, 1, 1, 5'd2, 2'b00, 32'h99, 32'h0, 0, 32'h0);
        sb.push_back('{5'd2, 32'h99});
        exp_inst++;
        tick();
        idle();
        tick();
        n_cmp++;
        if (sb.size() != 0 || wb_if.o_instret !== exp_inst) begin
            n_err++;
            $display("FAIL bubble_alive: pending=%0d instret=%0d, required 0/%0d",
                     sb.size(), wb_if.o_instret, exp_inst);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_inst = 0;
        rstn     = 1'b0;
        idle();
        test_reset();
        test_alu();
        test_jal();
        test_load_miss();
        test_back_to_back();
        test_timeout();
        test_reset_wait_and_bubbles();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
